// File: rtl/fb_draw_pkg.sv
// Shared types and default geometry for the rectangle drawer that feeds the
// write side of the double-buffered frame buffer.
package fb_draw_pkg;

    localparam int FB_WIDTH_DEFAULT  = 320;
    localparam int FB_HEIGHT_DEFAULT = 180;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_FILL  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_SWAP  = 2'd3
    } draw_op_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_FILL      = 3'd2,
        ST_WAIT_SYNC = 3'd3,
        ST_SWAP      = 3'd4
    } state_t;

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational clip of a rectangle against the buffer: inclusive end corner
// plus an empty flag for rectangles that produce no pixels.
module fb_rect_clip
    import fb_draw_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DEFAULT,
    parameter int FB_HEIGHT = FB_HEIGHT_DEFAULT,
    localparam int XW = $clog2(FB_WIDTH),
    localparam int YW = $clog2(FB_HEIGHT)
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [XW:0]   w,
    input  logic [YW:0]   h,
    output logic [XW-1:0] x_end,
    output logic [YW-1:0] y_end,
    output logic          empty
);

    localparam int XSW = XW + 2;
    localparam int YSW = YW + 2;

    logic [XSW-1:0] x_sum_s, x_lim_s, x_full_s;
    logic [YSW-1:0] y_sum_s, y_lim_s, y_full_s;

    // Clamp the far edge to the buffer; the wide sums cannot overflow.
    always_comb begin
        x_sum_s = XSW'(x) + XSW'(w);
        y_sum_s = YSW'(y) + YSW'(h);
        if (x_sum_s > XSW'(FB_WIDTH)) begin
            x_lim_s = XSW'(FB_WIDTH);
        end else begin
            x_lim_s = x_sum_s;
        end
        if (y_sum_s > YSW'(FB_HEIGHT)) begin
            y_lim_s = YSW'(FB_HEIGHT);
        end else begin
            y_lim_s = y_sum_s;
        end
        x_full_s = x_lim_s - XSW'(1);
        y_full_s = y_lim_s - YSW'(1);
        // Upper-bit test catches the underflow of a zero-area origin rectangle.
        empty = (w == (XW+1)'(0)) || (h == (YW+1)'(0))
             || (XSW'(x) >= XSW'(FB_WIDTH)) || (YSW'(y) >= YSW'(FB_HEIGHT))
             || (x_full_s[XSW-1:XW] != 2'b00) || (y_full_s[YSW-1:YW] != 2'b00);
        x_end = x_full_s[XW-1:0];
        y_end = y_full_s[YW-1:0];
    end

endmodule

// File: rtl/fb_rect_drawer.sv
// Command-driven pixel writer: clipped rectangle fills, full clears and
// frame-sync-aligned buffer swaps towards the frame buffer write port.
module fb_rect_drawer
    import fb_draw_pkg::*;
#(
    parameter int FB_WIDTH       = FB_WIDTH_DEFAULT,
    parameter int FB_HEIGHT      = FB_HEIGHT_DEFAULT,
    parameter int SWAP_WAIT_SYNC = 1,
    localparam int FB_SIZE = $clog2(FB_WIDTH * FB_HEIGHT),
    localparam int XW      = $clog2(FB_WIDTH),
    localparam int YW      = $clog2(FB_HEIGHT)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               cmd_valid_in,
    output logic               cmd_ready_out,
    input  logic [1:0]         cmd_op_in,
    input  logic [XW-1:0]      cmd_x_in,
    input  logic [YW-1:0]      cmd_y_in,
    input  logic [XW:0]        cmd_w_in,
    input  logic [YW:0]        cmd_h_in,
    input  logic [15:0]        cmd_color_in,
    input  logic               frame_sync_in,
    output logic [15:0]        write_data_out,
    output logic [FB_SIZE-1:0] write_addr_out,
    output logic               write_enable_out,
    output logic               swap_buffer_out,
    output logic               busy_out
);

    localparam logic [FB_SIZE-1:0] ROW_STEP = FB_SIZE'(FB_WIDTH);
    localparam logic [XW:0]        FULL_W   = (XW+1)'(FB_WIDTH);
    localparam logic [YW:0]        FULL_H   = (YW+1)'(FB_HEIGHT);

    state_t             state_r, state_next_s;
    draw_op_t           op_s;
    logic [XW-1:0]      x_start_r, x_end_r, x_end_next_s, x_r, x_next_s;
    logic [YW-1:0]      y_start_r, y_end_r, y_end_next_s, y_r, y_next_s;
    logic [XW:0]        w_r;
    logic [YW:0]        h_r;
    logic [15:0]        color_r;
    logic [FB_SIZE-1:0] row_base_r, row_base_next_s;
    logic [XW-1:0]      clip_x_end_s;
    logic [YW-1:0]      clip_y_end_s;
    logic               clip_empty_s;
    logic               accept_fill_s, accept_clear_s;

    assign op_s = draw_op_t'(cmd_op_in);

    fb_rect_clip #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT)
    ) u_clip (
        .x     (x_start_r),
        .y     (y_start_r),
        .w     (w_r),
        .h     (h_r),
        .x_end (clip_x_end_s),
        .y_end (clip_y_end_s),
        .empty (clip_empty_s)
    );

    // Next-state, accept decode and raster counter advance.
    always_comb begin
        state_next_s    = state_r;
        x_next_s        = x_r;
        y_next_s        = y_r;
        row_base_next_s = row_base_r;
        x_end_next_s    = x_end_r;
        y_end_next_s    = y_end_r;
        accept_fill_s   = 1'b0;
        accept_clear_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid_in) begin
                    case (op_s)
                        OP_FILL: begin
                            accept_fill_s = 1'b1;
                            state_next_s  = ST_SETUP;
                        end
                        OP_CLEAR: begin
                            accept_clear_s = 1'b1;
                            state_next_s   = ST_SETUP;
                        end
                        OP_SWAP: begin
                            if (SWAP_WAIT_SYNC != 0) begin
                                state_next_s = ST_WAIT_SYNC;
                            end else begin
                                state_next_s = ST_SWAP;
                            end
                        end
                        default: state_next_s = ST_IDLE;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (clip_empty_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s    = ST_FILL;
                    x_next_s        = x_start_r;
                    y_next_s        = y_start_r;
                    x_end_next_s    = clip_x_end_s;
                    y_end_next_s    = clip_y_end_s;
                    row_base_next_s = FB_SIZE'(y_start_r) * ROW_STEP;
                end
            end
            ST_FILL: begin
                // Counters name the pixel on the write port this cycle.
                if (x_r == x_end_r) begin
                    if (y_r == y_end_r) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        x_next_s        = x_start_r;
                        y_next_s        = y_r + YW'(1);
                        row_base_next_s = row_base_r + ROW_STEP;
                    end
                end else begin
                    x_next_s = x_r + XW'(1);
                end
            end
            ST_WAIT_SYNC: begin
                if (frame_sync_in) begin
                    state_next_s = ST_SWAP;
                end else begin
                    state_next_s = ST_WAIT_SYNC;
                end
            end
            ST_SWAP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, captured command fields and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r          <= ST_IDLE;
            x_start_r        <= '0;
            y_start_r        <= '0;
            w_r              <= '0;
            h_r              <= '0;
            color_r          <= 16'h0000;
            x_end_r          <= '0;
            y_end_r          <= '0;
            x_r              <= '0;
            y_r              <= '0;
            row_base_r       <= '0;
            cmd_ready_out    <= 1'b1;
            busy_out         <= 1'b0;
            write_enable_out <= 1'b0;
            swap_buffer_out  <= 1'b0;
            write_addr_out   <= '0;
            write_data_out   <= 16'h0000;
        end else begin
            state_r    <= state_next_s;
            x_end_r    <= x_end_next_s;
            y_end_r    <= y_end_next_s;
            x_r        <= x_next_s;
            y_r        <= y_next_s;
            row_base_r <= row_base_next_s;
            if (accept_fill_s) begin
                x_start_r <= cmd_x_in;
                y_start_r <= cmd_y_in;
                w_r       <= cmd_w_in;
                h_r       <= cmd_h_in;
                color_r   <= cmd_color_in;
            end else if (accept_clear_s) begin
                x_start_r <= '0;
                y_start_r <= '0;
                w_r       <= FULL_W;
                h_r       <= FULL_H;
                color_r   <= cmd_color_in;
            end
            cmd_ready_out    <= (state_next_s == ST_IDLE);
            busy_out         <= (state_next_s != ST_IDLE);
            write_enable_out <= (state_next_s == ST_FILL);
            swap_buffer_out  <= (state_next_s == ST_SWAP);
            if (state_next_s == ST_FILL) begin
                write_addr_out <= row_base_next_s + FB_SIZE'(x_next_s);
                write_data_out <= color_r;
            end
        end
    end

endmodule

// File: tb/tb_fb_rect_drawer.sv
// Scoreboard bench for fb_rect_drawer: a geometric reference model queues the
// expected write/swap stream, a negedge monitor checks what the DUT emits.
module tb_fb_rect_drawer;

    localparam int W = 320;
    localparam int H = 180;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        cmd_valid_in;
    logic        cmd_ready_out;
    logic [1:0]  cmd_op_in;
    logic [8:0]  cmd_x_in;
    logic [7:0]  cmd_y_in;
    logic [9:0]  cmd_w_in;
    logic [8:0]  cmd_h_in;
    logic [15:0] cmd_color_in;
    logic        frame_sync_in;
    logic [15:0] write_data_out;
    logic [15:0] write_addr_out;
    logic        write_enable_out;
    logic        swap_buffer_out;
    logic        busy_out;

    typedef struct {
        bit is_swap;
        int addr;
        int data;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    fb_rect_drawer #(.FB_WIDTH(W), .FB_HEIGHT(H), .SWAP_WAIT_SYNC(1)) dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .cmd_valid_in     (cmd_valid_in),
        .cmd_ready_out    (cmd_ready_out),
        .cmd_op_in        (cmd_op_in),
        .cmd_x_in         (cmd_x_in),
        .cmd_y_in         (cmd_y_in),
        .cmd_w_in         (cmd_w_in),
        .cmd_h_in         (cmd_h_in),
        .cmd_color_in     (cmd_color_in),
        .frame_sync_in    (frame_sync_in),
        .write_data_out   (write_data_out),
        .write_addr_out   (write_addr_out),
        .write_enable_out (write_enable_out),
        .swap_buffer_out  (swap_buffer_out),
        .busy_out         (busy_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe the DUT presents is matched against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (write_enable_out && swap_buffer_out) begin
            check("write_and_swap_overlap", 1, 0);
        end
        if (write_enable_out || swap_buffer_out) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output_addr", int'(write_addr_out), -1);
            end else begin
                e = sb_q.pop_front();
                check("event_kind_swap", int'(swap_buffer_out), int'(e.is_swap));
                if (!e.is_swap) begin
                    check("write_addr", int'(write_addr_out), e.addr);
                    check("write_data", int'(write_data_out), e.data);
                end
            end
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (!cmd_ready_out && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("ready_before_cmd", int'(cmd_ready_out), 1);
    endtask

    task automatic drive_cmd(input int op, input int x, input int y, input int w,
                             input int h, input int color, input bit sync);
        cmd_valid_in  = 1'b1;
        cmd_op_in     = 2'(op);
        cmd_x_in      = 9'(x);
        cmd_y_in      = 8'(y);
        cmd_w_in      = 10'(w);
        cmd_h_in      = 9'(h);
        cmd_color_in  = 16'(color);
        frame_sync_in = sync;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_in  = 1'b0;
        frame_sync_in = 1'b0;
    endtask

    // FILL / CLEAR / NOP: model the clipped raster, then time the command.
    task automatic send_draw(input int op, input int x, input int y, input int w,
                             input int h, input int color);
        int mx, my, mw, mh, xe, ye, p, exp_lat, k, wr;
        bit contig, busy_bad;
        exp_t e;
        mx = x; my = y; mw = w; mh = h; p = 0;
        if (op == 2) begin
            mx = 0; my = 0; mw = W; mh = H;
        end
        if ((op == 1 || op == 2) && mw > 0 && mh > 0 && mx < W && my < H) begin
            xe = (mx + mw < W) ? mx + mw : W;
            ye = (my + mh < H) ? my + mh : H;
            for (int yy = my; yy < ye; yy++) begin
                for (int xx = mx; xx < xe; xx++) begin
                    e.is_swap = 1'b0;
                    e.addr    = yy * W + xx;
                    e.data    = color;
                    sb_q.push_back(e);
                    p++;
                end
            end
        end
        exp_lat = (op == 0) ? 1 : p + 2;
        wait_ready();
        drive_cmd(op, x, y, w, h, color, 1'b0);
        k = 1; wr = 0; contig = 1'b1; busy_bad = 1'b0;
        while (!cmd_ready_out && k < p + 60) begin
            if (write_enable_out) begin
                wr++;
                if (k < 2 || k > p + 1) contig = 1'b0;
            end else if (k >= 2 && k <= p + 1) begin
                contig = 1'b0;
            end
            if (!busy_out) busy_bad = 1'b1;
            if (swap_buffer_out) busy_bad = 1'b1;
            frame_sync_in = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            k++;
        end
        frame_sync_in = 1'b0;
        check("ready_latency", k, exp_lat);
        check("write_count", wr, p);
        check("writes_contiguous", int'(contig), 1);
        check("busy_while_active", int'(busy_bad), 0);
        check("idle_busy_low", int'(busy_out), 0);
    endtask

    // SWAP: sync pulse delay cycles after accept, pulse expected one cycle later.
    task automatic send_swap(input int delay, input bit sync_at_accept);
        int k, nsw, sw_k;
        exp_t e;
        e.is_swap = 1'b1; e.addr = 0; e.data = 0;
        sb_q.push_back(e);
        wait_ready();
        drive_cmd(3, 0, 0, 0, 0, 0, sync_at_accept);
        k = 1; nsw = 0; sw_k = -1;
        while (!cmd_ready_out && k < delay + 60) begin
            frame_sync_in = (k == delay);
            if (swap_buffer_out) begin
                nsw++;
                sw_k = k;
            end
            @(negedge clk);
            k++;
        end
        frame_sync_in = 1'b0;
        check("swap_pulse_count", nsw, 1);
        check("swap_pulse_cycle", sw_k, delay + 1);
        check("swap_ready_latency", k, delay + 2);
    endtask

    task automatic reset_mid_clear();
        int cnt = 0;
        int g = 0;
        exp_t e;
        for (int i = 0; i < 100; i++) begin
            e.is_swap = 1'b0; e.addr = i; e.data = 16'h07E0;
            sb_q.push_back(e);
        end
        wait_ready();
        drive_cmd(2, 0, 0, 0, 0, 16'h07E0, 1'b0);
        while (cnt < 100 && g < 400) begin
            if (write_enable_out) cnt++;
            if (cnt < 100) begin
                @(negedge clk);
                g++;
            end
        end
        check("writes_before_reset", cnt, 100);
        rst_in = 1'b1;
        @(negedge clk);
        check("rst_we_low", int'(write_enable_out), 0);
        check("rst_ready_high", int'(cmd_ready_out), 1);
        check("rst_busy_low", int'(busy_out), 0);
        check("rst_swap_low", int'(swap_buffer_out), 0);
        check("rst_addr_zero", int'(write_addr_out), 0);
        rst_in = 1'b0;
        @(negedge clk);
        check("queue_drained_at_reset", sb_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, x, y, w, h;
        rst_in = 1'b1; cmd_valid_in = 1'b0; cmd_op_in = 2'd0;
        cmd_x_in = 9'd0; cmd_y_in = 8'd0; cmd_w_in = 10'd0; cmd_h_in = 9'd0;
        cmd_color_in = 16'h0000; frame_sync_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", int'(cmd_ready_out), 1);
        check("reset_busy", int'(busy_out), 0);
        check("reset_we", int'(write_enable_out), 0);
        check("reset_swap", int'(swap_buffer_out), 0);
        check("reset_addr", int'(write_addr_out), 0);
        check("reset_data", int'(write_data_out), 0);
        rst_in = 1'b0;
        @(negedge clk);

        send_draw(1, 10, 5, 3, 2, 16'hF800);
        send_draw(1, 318, 178, 10, 10, 16'h1234);
        send_draw(1, 7, 7, 0, 5, 16'hAAAA);
        send_draw(1, 400, 7, 5, 5, 16'h5555);
        send_draw(1, 3, 179, 4, 0, 16'h0F0F);
        send_draw(0, 1, 1, 1, 1, 16'hFFFF);
        send_swap(7, 1'b1);
        send_draw(1, 0, 0, 2, 2, 16'hBEEF);
        send_draw(1, 319, 0, 1, 1, 16'h0001);

        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 9);
            x  = ($urandom_range(0, 7) == 0) ? $urandom_range(300, 511) : $urandom_range(0, 319);
            y  = ($urandom_range(0, 7) == 0) ? $urandom_range(170, 255) : $urandom_range(0, 179);
            w  = $urandom_range(0, 16);
            h  = $urandom_range(0, 12);
            if (op < 7) begin
                send_draw(1, x, y, w, h, $urandom_range(0, 65535));
            end else if (op < 9) begin
                send_swap($urandom_range(1, 12), $urandom_range(0, 1) == 1);
            end else begin
                send_draw(0, x, y, w, h, 0);
            end
        end

        send_draw(2, 5, 5, 1, 1, 16'h001F);
        reset_mid_clear();
        send_draw(1, 5, 2, 4, 1, 16'hC0DE);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
